// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared types and helpers for the layer sequencer.
//   - state_t      : sequencer FSM state encoding
//   - safe_clog2   : address width helper (never returns zero)
//   - sat_add_w    : signed saturating add clamped to a w-bit result
//   - DEF_*        : derived constants for the default configuration
package layer_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACCUM = 3'd4,
    ST_WRITE = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  // A one-entry address space still needs a one-bit address port.
  function automatic int unsigned safe_clog2(input int unsigned v);
    int unsigned r;
    r = (v > 32'd1) ? $clog2(v) : 32'd1;
    return r;
  endfunction

  localparam int unsigned DEF_WIDTH = 32'd8;
  localparam int unsigned DEF_N     = 32'd2;
  localparam int unsigned DEF_NIN   = 32'd16;
  localparam int unsigned DEF_NOUT  = 32'd10;
  localparam int unsigned DEF_CH    = DEF_NIN / DEF_N;
  localparam int unsigned DEF_XAW   = safe_clog2(DEF_CH);
  localparam int unsigned DEF_WAW   = safe_clog2(DEF_NOUT * DEF_CH);
  localparam int unsigned DEF_NAW   = safe_clog2(DEF_NOUT);

  // Operands arrive sign-extended to 64 bits; the sum is formed one bit
  // wider so it can never wrap, then clamped to the signed range of w bits.
  function automatic logic signed [63:0] sat_add_w(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int unsigned        w
  );
    logic signed [64:0] sum;
    logic signed [64:0] max_v;
    logic signed [64:0] min_v;
    logic signed [64:0] res;
    sum   = {a[63], a} + {b[63], b};
    max_v = (65'sd1 <<< (w - 32'd1)) - 65'sd1;
    min_v = -(65'sd1 <<< (w - 32'd1));
    if (sum > max_v) begin
      res = max_v;
    end else if (sum < min_v) begin
      res = min_v;
    end else begin
      res = sum;
    end
    return res[63:0];
  endfunction

endpackage

// File: rtl/layer_seq_sat_add.sv
// sat_add: W-bit signed saturating adder (combinational).
//   a_i, b_i : signed W-bit operands
//   sum_o    : a_i + b_i clamped to [-2^(W-1), 2^(W-1)-1]
module sat_add
  import layer_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] sum_o
);

  logic signed [63:0] wide_s;
  logic               unused_hi_s;

  // Saturating sum in the wide domain, then keep the low W bits.
  always_comb begin
    wide_s      = sat_add_w(64'(a_i), 64'(b_i), W);
    sum_o       = wide_s[W-1:0];
    unused_hi_s = ^wide_s[63:W];
  end

endmodule

// File: rtl/layer_seq.sv
// layer_seq: sequences one fully-connected layer through an external MAC.
// For each neuron it loads the bias, streams CH chunks of N inputs/weights
// into the MAC, saturating-accumulates the partial results and emits one
// (optionally ReLU-clamped) output strobe.
//   clk, rst            : clock, async active-low reset
//   go, relu_en         : start pulse (IDLE only), ReLU select latched at go
//   busy, layer_done    : layer in progress, one-cycle completion pulse
//   x_addr/x_data       : input-vector chunk memory (1-cycle read latency)
//   w_addr/w_data       : weight chunk memory (1-cycle read latency)
//   n_idx/b_data        : current neuron and its combinational bias
//   mac_*               : operand/handshake interface to the external MAC
//   y_valid/y_idx/y_data: output strobe, neuron index, signed result
module layer_seq
  import layer_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 2,
  parameter int unsigned NIN   = 16,
  parameter int unsigned NOUT  = 10,
  parameter int unsigned CH    = NIN / N,
  parameter int unsigned XAW   = safe_clog2(CH),
  parameter int unsigned WAW   = safe_clog2(NOUT * CH),
  parameter int unsigned NAW   = safe_clog2(NOUT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      layer_done,
  output logic [XAW-1:0]            x_addr,
  input  logic [N*WIDTH-1:0]        x_data,
  output logic [WAW-1:0]            w_addr,
  input  logic [N*WIDTH-1:0]        w_data,
  output logic [NAW-1:0]            n_idx,
  input  logic [2*WIDTH-1:0]        b_data,
  output logic [N*WIDTH-1:0]        mac_a,
  output logic [N*WIDTH-1:0]        mac_b,
  output logic                      mac_start,
  input  logic                      mac_ack,
  input  logic                      mac_done,
  input  logic [2*WIDTH-1:0]        mac_acc,
  output logic                      y_valid,
  output logic [NAW-1:0]            y_idx,
  output logic signed [2*WIDTH-1:0] y_data
);

  localparam int unsigned AW = 2 * WIDTH;

  if ((NIN % N) != 0) begin : g_nin_check
    $error("layer_seq: NIN must be a multiple of N");
  end

  state_t                state_q;
  logic                  fetch_ph_q;
  logic [XAW-1:0]        chunk_q;
  logic [NAW-1:0]        n_idx_q;
  logic signed [AW-1:0]  psum_q;
  logic signed [AW-1:0]  psum_d;
  logic signed [AW-1:0]  acc_q;
  logic                  relu_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  y_valid_q;
  logic [NAW-1:0]        y_idx_q;
  logic signed [AW-1:0]  y_data_q;
  logic [N*WIDTH-1:0]    mac_a_q;
  logic [N*WIDTH-1:0]    mac_b_q;
  logic                  mac_start_q;
  logic [XAW-1:0]        x_addr_q;
  logic [WAW-1:0]        w_addr_q;

  sat_add #(.W(AW)) u_sat_add (
    .a_i   (psum_q),
    .b_i   (acc_q),
    .sum_o (psum_d)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fetch_ph_q  <= 1'b0;
      chunk_q     <= '0;
      n_idx_q     <= '0;
      psum_q      <= '0;
      acc_q       <= '0;
      relu_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      y_valid_q   <= 1'b0;
      y_idx_q     <= '0;
      y_data_q    <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_start_q <= 1'b0;
      x_addr_q    <= '0;
      w_addr_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go) begin
            n_idx_q    <= '0;
            chunk_q    <= '0;
            psum_q     <= $signed(b_data);
            relu_q     <= relu_en;
            busy_q     <= 1'b1;
            x_addr_q   <= '0;
            w_addr_q   <= '0;
            fetch_ph_q <= 1'b0;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Phase 0: address is at the memories (and n_idx is settled, so
          // the first chunk of a neuron picks up its bias here).
          // Phase 1: read data is valid and is latched as MAC operands.
          if (!fetch_ph_q) begin
            fetch_ph_q <= 1'b1;
            if (chunk_q == '0) begin
              psum_q <= $signed(b_data);
            end
          end else begin
            fetch_ph_q  <= 1'b0;
            mac_a_q     <= x_data;
            mac_b_q     <= w_data;
            mac_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mac_ack) begin
            mac_start_q <= 1'b0;
            // A MAC that finishes in the acknowledge cycle skips WAIT.
            if (mac_done) begin
              acc_q   <= $signed(mac_acc);
              state_q <= ST_ACCUM;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mac_done) begin
            acc_q   <= $signed(mac_acc);
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          psum_q <= psum_d;
          if (chunk_q == XAW'(CH - 1)) begin
            // The output is formed from the final sum now so that it is
            // already registered during WRITE.
            y_valid_q <= 1'b1;
            y_idx_q   <= n_idx_q;
            y_data_q  <= (relu_q && psum_d[AW-1]) ? '0 : psum_d;
            state_q   <= ST_WRITE;
          end else begin
            chunk_q  <= chunk_q + XAW'(1);
            x_addr_q <= chunk_q + XAW'(1);
            w_addr_q <= w_addr_q + WAW'(1);
            state_q  <= ST_FETCH;
          end
        end
        ST_WRITE: begin
          y_valid_q <= 1'b0;
          if (n_idx_q == NAW'(NOUT - 1)) begin
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            // Weights are stored neuron-major, so the next neuron's first
            // chunk directly follows the current neuron's last chunk.
            n_idx_q  <= n_idx_q + NAW'(1);
            chunk_q  <= '0;
            x_addr_q <= '0;
            w_addr_q <= w_addr_q + WAW'(1);
            state_q  <= ST_FETCH;
          end
        end
        ST_FIN: begin
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          n_idx_q  <= '0;
          chunk_q  <= '0;
          x_addr_q <= '0;
          w_addr_q <= '0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign layer_done = done_q;
  assign x_addr     = x_addr_q;
  assign w_addr     = w_addr_q;
  assign n_idx      = n_idx_q;
  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign mac_start  = mac_start_q;
  assign y_valid    = y_valid_q;
  assign y_idx      = y_idx_q;
  assign y_data     = y_data_q;

endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: self-checking bench for layer_seq (N=2, NIN=4, NOUT=2).
// A behavioural MAC and memories surround the DUT; a reference model
// computes each neuron's result from the input/weight/bias arrays.
module tb_layer_seq;

  localparam int W    = 8;
  localparam int N    = 2;
  localparam int NIN  = 4;
  localparam int NOUT = 2;
  localparam int CH   = NIN / N;
  localparam int AW   = 2 * W;
  localparam int XAW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int WAW  = (NOUT * CH > 1) ? $clog2(NOUT * CH) : 1;
  localparam int NAW  = (NOUT > 1) ? $clog2(NOUT) : 1;

  logic                 clk;
  logic                 rst;
  logic                 go;
  logic                 relu_en;
  logic                 busy;
  logic                 layer_done;
  logic [XAW-1:0]       x_addr;
  logic [N*W-1:0]       x_data;
  logic [WAW-1:0]       w_addr;
  logic [N*W-1:0]       w_data;
  logic [NAW-1:0]       n_idx;
  logic [AW-1:0]        b_data;
  logic [N*W-1:0]       mac_a;
  logic [N*W-1:0]       mac_b;
  logic                 mac_start;
  logic                 mac_ack;
  logic                 mac_done;
  logic [AW-1:0]        mac_acc;
  logic                 y_valid;
  logic [NAW-1:0]       y_idx;
  logic signed [AW-1:0] y_data;

  int xv [NIN];
  int wv [NOUT][NIN];
  int bv [NOUT];
  int cap [NOUT];

  int checks = 0;
  int errors = 0;
  int ld_count = 0;
  int y_count = 0;
  int mac_ackd = 1;
  int mac_doned = 3;
  int exp_idx [$];
  int exp_data [$];

  layer_seq #(.WIDTH(W), .N(N), .NIN(NIN), .NOUT(NOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .relu_en    (relu_en),
    .busy       (busy),
    .layer_done (layer_done),
    .x_addr     (x_addr),
    .x_data     (x_data),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .n_idx      (n_idx),
    .b_data     (b_data),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_start  (mac_start),
    .mac_ack    (mac_ack),
    .mac_done   (mac_done),
    .mac_acc    (mac_acc),
    .y_valid    (y_valid),
    .y_idx      (y_idx),
    .y_data     (y_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  function automatic int sat16(input int v);
    return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
  endfunction

  function automatic int rnd8();
    logic signed [7:0] t;
    t = 8'($urandom);
    return int'(t);
  endfunction

  // Reference: bias plus each chunk's (16-bit MAC) dot product, saturated
  // after every chunk, then optional ReLU.
  function automatic int model_y(input int n, input bit relu);
    int p;
    int s;
    p = bv[n];
    for (int c = 0; c < CH; c++) begin
      s = 0;
      for (int j = 0; j < N; j++) s += xv[c*N+j] * wv[n][c*N+j];
      p = sat16(p + wrap16(s));
    end
    return (relu && p < 0) ? 0 : p;
  endfunction

  function automatic logic [N*W-1:0] pack_x(input int c);
    logic [N*W-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = W'(xv[c*N+j]);
    return r;
  endfunction

  function automatic logic [N*W-1:0] pack_w(input int a);
    logic [N*W-1:0] r;
    for (int j = 0; j < N; j++) r[j*W +: W] = W'(wv[a/CH][(a%CH)*N+j]);
    return r;
  endfunction

  function automatic int dot(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    int s;
    s = 0;
    for (int j = 0; j < N; j++) s += int'($signed(a[j*W +: W])) * int'($signed(b[j*W +: W]));
    return s;
  endfunction

  // Synchronous-read memories and combinational bias lookup.
  always @(posedge clk) begin
    x_data <= pack_x(int'(x_addr));
    w_data <= pack_w(int'(w_addr));
  end
  assign b_data = 16'(bv[n_idx]);

  // Behavioural MAC: ack after mac_ackd cycles, done after mac_doned cycles.
  initial begin
    int cnt;
    int acc_v;
    cnt = -1;
    acc_v = 0;
    mac_ack = 1'b0;
    mac_done = 1'b0;
    mac_acc = '0;
    forever begin
      @(posedge clk);
      #1;
      mac_ack = 1'b0;
      mac_done = 1'b0;
      if (!rst) begin
        cnt = -1;
      end else if (cnt < 0 && mac_start) begin
        acc_v = dot(mac_a, mac_b);
        cnt = 0;
      end
      if (cnt >= 0) begin
        cnt++;
        if (cnt == mac_ackd) mac_ack = 1'b1;
        if (cnt == mac_doned) begin
          mac_done = 1'b1;
          mac_acc = 16'(acc_v);
          cnt = -1;
        end
      end
    end
  end

  // Per-cycle compare against the model queue and MAC protocol rules.
  logic           prev_start;
  logic           prev_ack;
  logic [N*W-1:0] prev_a;
  logic [N*W-1:0] prev_b;
  int             starts_nrn;
  initial begin
    prev_start = 1'b0;
    prev_ack = 1'b0;
    prev_a = '0;
    prev_b = '0;
    starts_nrn = 0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      starts_nrn = 0;
      prev_start = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (mac_start && !prev_start) starts_nrn++;
      if (prev_start && prev_ack) chk("start_drop_after_ack", int'(mac_start), 0);
      if (mac_start && prev_start) begin
        chk("mac_a_stable", int'(mac_a == prev_a), 1);
        chk("mac_b_stable", int'(mac_b == prev_b), 1);
      end
      if (y_valid) begin
        y_count++;
        chk("starts_per_neuron", starts_nrn, CH);
        starts_nrn = 0;
        if (exp_idx.size() == 0) begin
          chk("unexpected_y_valid", 1, 0);
        end else begin
          chk("y_idx", int'(y_idx), exp_idx.pop_front());
          chk("y_data", int'(y_data), exp_data.pop_front());
        end
        cap[y_idx] = int'(y_data);
      end
      if (layer_done) begin
        ld_count++;
        chk("outputs_left_at_done", exp_idx.size(), 0);
      end
      prev_start = mac_start;
      prev_ack = mac_ack;
      prev_a = mac_a;
      prev_b = mac_b;
    end
  end

  task automatic push_expected(input bit relu);
    for (int n = 0; n < NOUT; n++) begin
      exp_idx.push_back(n);
      exp_data.push_back(model_y(n, relu));
      cap[n] = 99999;
    end
  endtask

  task automatic start_layer(input bit relu);
    @(posedge clk);
    #1;
    go = 1'b1;
    relu_en = relu;
    @(posedge clk);
    #1;
    go = 1'b0;
    relu_en = ~relu;  // must have been latched at go
    chk("busy_after_go", int'(busy), 1);
  endtask

  task automatic run_layer(input int ackd, input int doned, input bit relu, input bit glitch);
    int ld0;
    int yc0;
    bit seen;
    mac_ackd = ackd;
    mac_doned = doned;
    push_expected(relu);
    ld0 = ld_count;
    yc0 = y_count;
    start_layer(relu);
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk);
      #1;
      go = (glitch && (i == 8 || i == 9)) ? 1'b1 : 1'b0;
      if (layer_done) seen = 1'b1;
    end
    go = 1'b0;
    chk("layer_done_seen", int'(seen), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_after_done", int'(busy), 0);
    chk("layer_done_count", ld_count - ld0, 1);
    chk("y_count", y_count - yc0, NOUT);
    exp_idx.delete();
    exp_data.delete();
  endtask

  task automatic set_base();
    for (int i = 0; i < NIN; i++) begin
      xv[i] = i + 1;
      wv[0][i] = 1;
      wv[1][i] = 0;
    end
    wv[1][0] = 2;
    wv[1][3] = -1;
    bv[0] = 0;
    bv[1] = 5;
  endtask

  task automatic reset_mid_layer();
    bit ok;
    int ld0;
    mac_ackd = 1;
    mac_doned = 3;
    push_expected(1'b0);
    ld0 = ld_count;
    start_layer(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (n_idx == NAW'(1) && mac_start) ok = 1'b1;
    end
    chk("reached_neuron1_issue", int'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (!mac_start) ok = 1'b1;
    end
    chk("reached_neuron1_wait", int'(ok), 1);
    rst = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_mac_start", int'(mac_start), 0);
    chk("rst_mac_a", int'(mac_a), 0);
    chk("rst_mac_b", int'(mac_b), 0);
    chk("rst_n_idx", int'(n_idx), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_x_addr", int'(x_addr), 0);
    chk("rst_y_data", int'(y_data), 0);
    chk("rst_y_idx", int'(y_idx), 0);
    exp_idx.delete();
    exp_data.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold_y_valid", int'(y_valid), 0);
      chk("rst_hold_layer_done", int'(layer_done), 0);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_abort", ld_count - ld0, 0);
    chk("idle_after_abort", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b0;
    go = 1'b0;
    relu_en = 1'b0;
    set_base();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_layer_done", int'(layer_done), 0);
    chk("reset_y_valid", int'(y_valid), 0);
    chk("reset_mac_start", int'(mac_start), 0);
    chk("reset_y_data", int'(y_data), 0);
    rst = 1'b1;

    // Directed base case and its literal results.
    chk("model_base_y0", model_y(0, 1'b0), 10);
    chk("model_base_y1", model_y(1, 1'b0), 3);
    run_layer(1, 3, 1'b0, 1'b0);
    chk("base_y0", cap[0], 10);
    chk("base_y1", cap[1], 3);

    // go held during the layer is ignored.
    run_layer(1, 3, 1'b0, 1'b1);
    chk("glitch_y0", cap[0], 10);
    chk("glitch_y1", cap[1], 3);

    // ack and done together, and slow acknowledge.
    run_layer(1, 1, 1'b0, 1'b0);
    chk("ackdone_same_y1", cap[1], 3);
    run_layer(5, 5, 1'b0, 1'b0);
    chk("ack5_same_y1", cap[1], 3);
    run_layer(5, 7, 1'b0, 1'b0);
    chk("ack5_done7_y0", cap[0], 10);
    chk("ack5_done7_y1", cap[1], 3);

    // Negative neuron with and without ReLU.
    for (int i = 0; i < NIN; i++) wv[1][i] = -4;
    chk("model_neg_y1", model_y(1, 1'b0), -35);
    run_layer(1, 3, 1'b1, 1'b0);
    chk("relu_y0", cap[0], 10);
    chk("relu_y1", cap[1], 0);
    run_layer(1, 3, 1'b0, 1'b0);
    chk("norelu_y1", cap[1], -35);

    // Saturation in both directions.
    for (int i = 0; i < NIN; i++) begin
      xv[i] = 127;
      wv[0][i] = 127;
      wv[1][i] = -127;
    end
    bv[0] = 30000;
    bv[1] = -30000;
    chk("model_sat_pos", model_y(0, 1'b0), 32767);
    run_layer(2, 4, 1'b0, 1'b0);
    chk("sat_pos_y0", cap[0], 32767);
    chk("sat_neg_y1", cap[1], -32768);

    // Reset in the middle of neuron 1, then a full clean layer.
    set_base();
    reset_mid_layer();
    run_layer(1, 3, 1'b0, 1'b0);
    chk("after_reset_y0", cap[0], 10);
    chk("after_reset_y1", cap[1], 3);

    // Randomized layers against the model.
    for (int r = 0; r < 10; r++) begin
      int a;
      for (int i = 0; i < NIN; i++) begin
        xv[i] = rnd8();
        for (int n = 0; n < NOUT; n++) wv[n][i] = rnd8();
      end
      for (int n = 0; n < NOUT; n++) bv[n] = wrap16(int'($urandom));
      a = int'($urandom_range(1, 5));
      run_layer(a, a + int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_seq.md
LAYER_SEQ -- requirements
Module: layer_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand width of one signed fixed-point element.
REQ-002 Parameter: N, 2, lanes per MAC issue; equals the macfp N it drives.
REQ-003 Parameter: NIN, 16, inputs per neuron; SHALL be a multiple of N (elaboration error otherwise).
REQ-004 Parameter: NOUT, 10, neurons per layer.
REQ-005 Derived: CH = NIN/N chunks per neuron; XAW = clog2(CH); WAW = clog2(NOUT*CH); NAW = clog2(NOUT).
REQ-006 Port: clk  in  1  sole clock, rising edge.
REQ-007 Port: rst  in  1  asynchronous active-low reset.
REQ-008 Port: go  in  1  start layer pulse; sampled only in IDLE.
REQ-009 Port: relu_en  in  1  apply ReLU to outputs; sampled at go.
REQ-010 Port: busy  out  1  high from go acceptance until layer_done.
REQ-011 Port: layer_done  out  1  one-cycle pulse after last neuron written.
REQ-012 Port: x_addr  out  XAW  input-vector chunk address; x_data  in  N*WIDTH  read data, 1-cycle latency.
REQ-013 Port: w_addr  out  WAW  weight chunk address; w_data  in  N*WIDTH  read data, 1-cycle latency.
REQ-014 Port: n_idx  out  NAW  current neuron; b_data  in  2*WIDTH  bias of n_idx, valid combinationally.
REQ-015 Port: mac_a, mac_b  out  N*WIDTH  operands to MAC; mac_start  out  1; mac_ack, mac_done  in  1; mac_acc  in  2*WIDTH.
REQ-016 Port: y_valid  out  1  one-cycle output strobe; y_idx  out  NAW; y_data  out  2*WIDTH signed.

Function
REQ-017 FSM states: IDLE, FETCH, ISSUE, WAIT, ACCUM, WRITE, FIN.
REQ-018 IDLE: on go, n_idx<=0, chunk<=0, psum<=b_data sign-preserved, relu latched, busy<=1, -> FETCH.
REQ-019 FETCH: x_addr=chunk, w_addr=n_idx*CH+chunk driven; one cycle later register x_data/w_data into mac_a/mac_b -> ISSUE.
REQ-020 ISSUE: mac_start=1, mac_a/mac_b held stable; on mac_ack=1 drop mac_start next cycle -> WAIT.
REQ-021 WAIT: mac_a/mac_b held; on mac_done=1 capture mac_acc -> ACCUM; mac_done arriving in the same cycle as mac_ack SHALL be honoured (ISSUE -> ACCUM directly).
REQ-022 ACCUM: psum <= sat(psum + captured acc), signed saturation to 2*WIDTH bits (clamp to max/min, no wrap); if chunk==CH-1 -> WRITE else chunk+1 -> FETCH.
REQ-023 WRITE: y_valid=1 for one cycle, y_idx=n_idx, y_data = (relu && psum<0) ? 0 : psum; if n_idx==NOUT-1 -> FIN else n_idx+1, chunk<=0, psum<=bias of new neuron (loaded next cycle) -> FETCH.
REQ-024 FIN: layer_done=1 one cycle, busy<=0 -> IDLE.
REQ-025 go while busy SHALL be ignored; no queuing.
REQ-026 Per-chunk latency without stalls: FETCH 2 cycles, ISSUE >=1, WAIT per MAC, ACCUM 1; no cycle cap on mac_ack/mac_done waits.
REQ-027 mac_start SHALL never be asserted outside ISSUE; exactly one start per chunk.

Reset
REQ-028 rst low asynchronously forces IDLE; busy, layer_done, y_valid, mac_start = 0; mac_a, mac_b, y_data, psum = 0; x_addr, w_addr, n_idx, y_idx, chunk = 0.
REQ-029 Reset mid-layer SHALL abandon the layer with no y_valid or layer_done; next go restarts at neuron 0.

Structure
REQ-030 Shared package holds state enum, saturating-add function, and derived width constants.
REQ-031 One sub-module natural: sat_add (2*WIDTH signed saturating adder); MAC itself external.

Verification
REQ-032 N=2,NIN=4,NOUT=2, x=[1,2,3,4], w0=[1,1,1,1], w1=[2,0,0,-1], biases 0,5, MAC model ack/done 1/3 cycles -> y_idx0=10, y_idx1=3, then layer_done.
REQ-033 Same, w1=[-4,-4,-4,-4], relu_en=1 -> y_idx1=0; relu_en=0 -> y_idx1=-35.
REQ-034 Partial sums exceeding +32767 (WIDTH=8) -> y_data=32767, no wrap; negative overflow -> -32768.
REQ-035 MAC model asserting ack and done same cycle, and ack delayed 5 cycles -> identical outputs, mac_start deasserts one cycle after ack, exactly CH starts per neuron.
REQ-036 rst low in WAIT of neuron 1 -> all outputs zero immediately, no layer_done; go after release -> full correct layer.
REQ-037 go pulsed while busy -> ignored, single layer_done.
